// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit with fixed-latency MULT/DIV and single-cycle MTHI/MTLO
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [31:0] temp_hi, temp_lo;
  logic [31:0] ua, ub, uq, ur, q, r;
  logic [63:0] res;
  logic accept, md_go, fin, sgn;
  assign accept = start & ~cancel & (state == IDLE) & (op != 3'd0) & (op != 3'd7);
  assign md_go = accept & (op <= 3'd4);
  assign fin = (state == BUSY) && (cnt == 4'd1);
  assign busy = state == BUSY;
  // Signed divide works on magnitudes, then restores signs; this also yields
  // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  always_comb begin
    sgn = op == 3'd3;
    ua = (sgn & a[31]) ? -a : a;
    ub = (sgn & b[31]) ? -b : b;
    uq = (ub == 32'd0) ? 32'd0 : ua / ub;
    ur = (ub == 32'd0) ? 32'd0 : ua % ub;
    q = (sgn & (a[31] ^ b[31])) ? -uq : uq;
    r = (sgn & a[31]) ? -ur : ur;
    res = (op == 3'd1) ? {{32{a[31]}}, a} * {{32{b[31]}}, b} :
          (op == 3'd2) ? {32'd0, a} * {32'd0, b} :
          (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {r, q};
  end
  always_comb state_nxt = md_go ? BUSY : fin ? IDLE : state;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= 4'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      hi <= 32'd0;
      lo <= 32'd0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= fin;
      if (md_go) begin
        {temp_hi, temp_lo} <= res;
        cnt <= (op <= 3'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end else if (busy) begin
        cnt <= cnt - 4'd1;
      end
      if (fin) begin
        hi <= temp_hi;
        lo <= temp_lo;
      end else if (accept && op == 3'd5) begin
        hi <= a;
      end else if (accept && op == 3'd6) begin
        lo <= a;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; expected HI/LO queued at issue, checked on done
module tb_md_unit;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic busy, done;
  logic [31:0] hi, lo;
  logic [63:0] sb[$];
  int total = 0, pass_cnt = 0;

  md_unit dut (
    .clk(clk), .resetn(resetn), .start(start), .cancel(cancel), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    longint lx, ly, lq, lr;
    logic [63:0] p;
    sx = x;
    sy = y;
    lx = sx;
    ly = sy;
    if (o == 3'd1) return lx * ly;
    if (o == 3'd2) begin
      p = {32'd0, x} * {32'd0, y};
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 3'd3) begin
      lq = lx / ly;
      lr = lx % ly;
      return {lr[31:0], lq[31:0]};
    end
    return {x % y, x / y};
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("hi", hi, e[63:32]);
        check("lo", lo, e[31:0]);
      end
    end
  end

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] e, input int inj);
    int n, c;
    n = (o <= 3'd2) ? 5 : 10;
    c = 0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    while (busy && c < 40) begin
      c++;
      if (c == inj) begin
        start = 1'b1; op = 3'd6; a = 32'hAA;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_len", 64'(c), 64'(n));
    check("done_rise", 64'(done), 1);
    @(negedge clk);
    check("done_pulse", 64'(done), 0);
  endtask

  initial begin
    logic [31:0] h0, l0, x, y;
    logic [2:0] o;
    logic seen;
    repeat (2) @(negedge clk);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    resetn = 1'b1;
    run(3'd1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run(3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    run(3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run(3'd3, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 0);
    run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    run(3'd4, 32'hDEAD_BEEF, 32'd0, {32'hDEAD_BEEF, 32'hFFFF_FFFF}, 0);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 2);
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_busy", 64'(busy), 0);
    check("cancel_hilo", {hi, lo}, {h0, l0});
    start = 1'b1; op = 3'd7; a = 32'h77;
    @(negedge clk);
    start = 1'b0;
    check("op7_ignored", {hi, lo, 31'd0, busy}, {h0, l0, 32'd0});
    start = 1'b1; op = 3'd5; a = 32'h55;
    @(negedge clk);
    start = 1'b0;
    check("mthi", {hi, lo}, {32'h55, l0});
    check("mthi_busy_done", {busy, done}, 0);
    start = 1'b1; op = 3'd6; a = 32'h66;
    @(negedge clk);
    start = 1'b0;
    check("mtlo", {hi, lo}, {32'h55, 32'h66});
    check("mtlo_busy_done", {busy, done}, 0);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 1);
    resetn = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 0);
    check("arst_hilo", {hi, lo}, 0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= done;
    end
    check("no_done_after_rst", 64'(seen), 0);
    check("hilo_after_rst", {hi, lo}, 0);
    run(3'd1, 32'd7, 32'd6, 64'd42, 0);
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = (i == 5) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      run(o, x, y, model(o, x, y), 0);
    end
    check("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
